// File: rtl/seg_page_scheduler.sv
// Four-page segment display scheduler. It copies one 8-word page into the display
// registers, holds it for a dwell period, and rotates between enabled or urgent pages.
//
// state | meaning
// IDLE  | no page enabled, display held at BLANK
// LOAD  | copying buf[CUR_PAGE][idx] to SEG_idx, one word per cycle
// SHOW  | page displayed, dwell counter running
module seg_page_scheduler #(
  parameter logic [23:0] DWELL_MAX = 24'd9_999_999,
  parameter logic [31:0] BLANK     = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WR_VALID,
  output logic        WR_READY,
  input  logic [1:0]  WR_PAGE,
  input  logic [2:0]  WR_IDX,
  input  logic [31:0] WR_DATA,
  input  logic [3:0]  PAGE_EN,
  input  logic [3:0]  URGENT,
  output logic [31:0] SEG_0,
  output logic [31:0] SEG_1,
  output logic [31:0] SEG_2,
  output logic [31:0] SEG_3,
  output logic [31:0] SEG_4,
  output logic [31:0] SEG_5,
  output logic [31:0] SEG_6,
  output logic [31:0] SEG_7,
  output logic [1:0]  CUR_PAGE,
  output logic        BUSY,
  output logic        SHOWING
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHOW} state_t;

  state_t      state_q, state_d;
  logic [1:0]  page_q, page_d;
  logic [2:0]  idx_q, idx_d;
  logic [23:0] cnt_q, cnt_d;
  logic [31:0] seg_q [8];
  logic [31:0] seg_d [8];
  logic [31:0] pbuf_q [32];

  logic        wr_fire;
  logic [3:0]  urg_en, elig;
  logic [2:0]  pick_any, pick_other;
  logic [1:0]  urg_low;

  // Round-robin search starting at from+1; offset 4 wraps back to from itself.
  // Returns {found, page}.
  function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] from);
    logic [2:0] r;
    logic [1:0] p;
    r = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      p = from + 2'(k);
      if (mask[p]) r = {1'b1, p};
    end
    return r;
  endfunction

  assign WR_READY = !(state_q == S_LOAD && WR_PAGE == page_q);
  assign wr_fire  = WR_VALID && WR_READY;
  assign urg_en   = PAGE_EN & URGENT;
  assign elig     = (|urg_en) ? urg_en : PAGE_EN;
  assign pick_any   = rr_pick(elig, page_q);
  assign pick_other = rr_pick(elig & ~(4'b0001 << page_q), page_q);

  always_comb begin
    urg_low = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (urg_en[i]) urg_low = 2'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    case (state_q)
      S_IDLE: begin
        if (|PAGE_EN) begin
          state_d = S_LOAD;
          page_d  = pick_any[1:0];
          idx_d   = 3'd0;
          cnt_d   = 24'd0;
        end
      end
      S_LOAD: begin
        seg_d[idx_q] = pbuf_q[{page_q, idx_q}];
        idx_d        = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          state_d = S_SHOW;
          cnt_d   = 24'd0;
        end
      end
      S_SHOW: begin
        if (wr_fire && WR_PAGE == page_q) seg_d[WR_IDX] = WR_DATA;
        if (!PAGE_EN[page_q]) begin
          cnt_d = 24'd0;
          if (pick_any[2]) begin
            state_d = S_LOAD;
            page_d  = pick_any[1:0];
            idx_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
            for (int i = 0; i < 8; i++) seg_d[i] = BLANK;
          end
        end else if (!URGENT[page_q] && |urg_en) begin
          state_d = S_LOAD;
          page_d  = urg_low;
          idx_d   = 3'd0;
          cnt_d   = 24'd0;
        end else if (cnt_q == DWELL_MAX) begin
          cnt_d = 24'd0;
          if (pick_other[2]) begin
            state_d = S_LOAD;
            page_d  = pick_other[1:0];
            idx_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      page_q  <= 2'd0;
      idx_q   <= 3'd0;
      cnt_q   <= 24'd0;
      for (int i = 0; i < 8; i++) seg_q[i] <= BLANK;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 32; i++) pbuf_q[i] <= 32'd0;
    end else if (wr_fire) begin
      pbuf_q[{WR_PAGE, WR_IDX}] <= WR_DATA;
    end
  end

  assign SEG_0    = seg_q[0];
  assign SEG_1    = seg_q[1];
  assign SEG_2    = seg_q[2];
  assign SEG_3    = seg_q[3];
  assign SEG_4    = seg_q[4];
  assign SEG_5    = seg_q[5];
  assign SEG_6    = seg_q[6];
  assign SEG_7    = seg_q[7];
  assign CUR_PAGE = page_q;
  assign BUSY     = (state_q == S_LOAD);
  assign SHOWING  = (state_q == S_SHOW);

endmodule

// File: tb/tb_seg_page_scheduler.sv
// Bench for seg_page_scheduler: a page-level behavioural model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_seg_page_scheduler;
  localparam int          DWELL = 4;
  localparam logic [31:0] BLNK  = 32'hDEAD_BEEF;
  localparam int ML_IDLE = 0, ML_LOAD = 1, ML_SHOW = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        WR_VALID, WR_READY;
  logic [1:0]  WR_PAGE;
  logic [2:0]  WR_IDX;
  logic [31:0] WR_DATA;
  logic [3:0]  PAGE_EN, URGENT;
  logic [31:0] SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7;
  logic [1:0]  CUR_PAGE;
  logic        BUSY, SHOWING;
  wire  [31:0] seg_w [8];

  assign seg_w[0] = SEG_0; assign seg_w[1] = SEG_1; assign seg_w[2] = SEG_2; assign seg_w[3] = SEG_3;
  assign seg_w[4] = SEG_4; assign seg_w[5] = SEG_5; assign seg_w[6] = SEG_6; assign seg_w[7] = SEG_7;

  seg_page_scheduler #(.DWELL_MAX(24'd4), .BLANK(BLNK)) dut (
    .CLK(CLK), .RST(RST), .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_PAGE(WR_PAGE),
    .WR_IDX(WR_IDX), .WR_DATA(WR_DATA), .PAGE_EN(PAGE_EN), .URGENT(URGENT),
    .SEG_0(SEG_0), .SEG_1(SEG_1), .SEG_2(SEG_2), .SEG_3(SEG_3),
    .SEG_4(SEG_4), .SEG_5(SEG_5), .SEG_6(SEG_6), .SEG_7(SEG_7),
    .CUR_PAGE(CUR_PAGE), .BUSY(BUSY), .SHOWING(SHOWING));

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Page-level model
  int          m_mode, m_page, m_idx, m_cnt;
  logic [31:0] m_buf [4][8];
  logic [31:0] m_seg [8];

  function automatic int rr_next(input logic [3:0] set, input int from, input bit skip_self);
    for (int k = 1; k <= 4; k++) begin
      int p;
      p = (from + k) % 4;
      if (!(skip_self && p == from) && set[p]) return p;
    end
    return -1;
  endfunction

  function automatic bit m_ready();
    return !(m_mode == ML_LOAD && int'(WR_PAGE) == m_page);
  endfunction

  task automatic model_reset();
    m_mode = ML_IDLE; m_page = 0; m_idx = 0; m_cnt = 0;
    for (int p = 0; p < 4; p++) for (int w = 0; w < 8; w++) m_buf[p][w] = 32'd0;
    for (int w = 0; w < 8; w++) m_seg[w] = BLNK;
  endtask

  task automatic model_step();
    logic [3:0] urg, el;
    bit accept, go;
    int target;
    urg = PAGE_EN & URGENT;
    el = (urg != 4'd0) ? urg : PAGE_EN;
    accept = WR_VALID && m_ready();
    go = 0; target = 0;
    if (m_mode == ML_IDLE) begin
      if (PAGE_EN != 4'd0) begin target = rr_next(el, m_page, 0); go = 1; end
    end else if (m_mode == ML_LOAD) begin
      m_seg[m_idx] = m_buf[m_page][m_idx];
      m_idx++;
      if (m_idx == 8) begin m_mode = ML_SHOW; m_idx = 0; m_cnt = 0; end
    end else begin
      if (accept && int'(WR_PAGE) == m_page) m_seg[WR_IDX] = WR_DATA;
      if (!PAGE_EN[m_page]) begin
        target = rr_next(el, m_page, 0);
        if (target < 0) begin
          m_mode = ML_IDLE; m_cnt = 0;
          for (int w = 0; w < 8; w++) m_seg[w] = BLNK;
        end else go = 1;
      end else if (!URGENT[m_page] && urg != 4'd0) begin
        for (int p = 3; p >= 0; p--) if (urg[p]) target = p;
        go = 1;
      end else if (m_cnt == DWELL) begin
        m_cnt = 0;
        target = rr_next(el, m_page, 1);
        if (target >= 0) go = 1;
      end else m_cnt++;
    end
    if (go) begin m_mode = ML_LOAD; m_page = target; m_idx = 0; m_cnt = 0; end
    if (accept) m_buf[WR_PAGE][WR_IDX] = WR_DATA;
  endtask

  always @(posedge CLK or negedge RST) begin
    if (!RST) model_reset();
    else model_step();
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("cmp_wr_ready", WR_READY, m_ready());
      check("cmp_cur_page", CUR_PAGE, m_page);
      check("cmp_busy", BUSY, m_mode == ML_LOAD);
      check("cmp_showing", SHOWING, m_mode == ML_SHOW);
      for (int w = 0; w < 8; w++) check($sformatf("cmp_seg%0d", w), seg_w[w], m_seg[w]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic wr(input logic [1:0] p, input logic [2:0] i, input logic [31:0] d);
    WR_VALID = 1'b1; WR_PAGE = p; WR_IDX = i; WR_DATA = d;
    tick(1);
    WR_VALID = 1'b0;
  endtask

  task automatic wait_show(input string name);
    for (int c = 0; c < 30 && !SHOWING; c++) tick(1);
    check(name, SHOWING, 1'b1);
  endtask

  int exp_seq [4] = '{0, 1, 3, 0};
  int seq[$];
  int slen[$];

  initial begin
    int busy_n, run, bad;
    bit prev;
    RST = 1'b0; WR_VALID = 1'b0; WR_PAGE = 2'd0; WR_IDX = 3'd0; WR_DATA = 32'd0;
    PAGE_EN = 4'd0; URGENT = 4'd0;
    tick(3);
    check("rst_busy", BUSY, 1'b0);
    check("rst_showing", SHOWING, 1'b0);
    check("rst_cur_page", CUR_PAGE, 2'd0);
    check("rst_seg0", SEG_0, BLNK);
    check("rst_seg7", SEG_7, BLNK);
    check("rst_wr_ready", WR_READY, 1'b1);
    RST = 1'b1;
    chk_en = 1;

    // Load page 1 with 11111111*(k+1) and show it
    for (int k = 0; k < 8; k++) wr(2'd1, 3'(k), 32'h1111_1111 * (k + 1));
    PAGE_EN = 4'b0010;
    busy_n = 0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (BUSY) busy_n++;
      else if (busy_n > 0) break;
    end
    check("p1_busy_cycles", busy_n, 8);
    check("p1_showing", SHOWING, 1'b1);
    check("p1_cur_page", CUR_PAGE, 2'd1);
    for (int k = 0; k < 8; k++) check($sformatf("p1_seg%0d", k), seg_w[k], 32'h1111_1111 * (k + 1));

    // Move to page 0, then rotate over pages 0,1,3
    PAGE_EN = 4'b0001;
    tick(1);
    check("to_p0_busy", BUSY, 1'b1);
    check("to_p0_page", CUR_PAGE, 2'd0);
    PAGE_EN = 4'b1011;
    run = 0; prev = 0;
    for (int c = 0; c < 80 && seq.size() < 4; c++) begin
      tick(1);
      if (SHOWING) begin
        if (!prev) seq.push_back(int'(CUR_PAGE));
        run++;
      end else if (prev) begin
        slen.push_back(run);
        run = 0;
      end
      prev = SHOWING;
    end
    check("rot_count", seq.size(), 4);
    for (int i = 0; i < seq.size(); i++) check($sformatf("rot_page%0d", i), seq[i], exp_seq[i]);
    check("rot_len_count", slen.size(), 3);
    for (int i = 0; i < slen.size(); i++) check($sformatf("rot_show_len%0d", i), slen[i], 5);

    // Urgent page 2 preempts page 0
    PAGE_EN = 4'b0101; URGENT = 4'b0100;
    tick(1);
    check("pre_busy", BUSY, 1'b1);
    check("pre_page", CUR_PAGE, 2'd2);

    // Writes during LOAD of page 2
    WR_VALID = 1'b1; WR_PAGE = 2'd2; WR_IDX = 3'd1; WR_DATA = 32'hA5A5_0001;
    #1 check("ld_block_a", WR_READY, 1'b0);
    tick(1);
    check("ld_block_b", WR_READY, 1'b0);
    WR_PAGE = 2'd3; WR_IDX = 3'd0; WR_DATA = 32'h3333_0000;
    #1 check("ld_other_ready", WR_READY, 1'b1);
    tick(1);
    WR_PAGE = 2'd2; WR_IDX = 3'd1; WR_DATA = 32'hA5A5_0001;
    wait_show("p2_show");
    check("show_ready", WR_READY, 1'b1);
    tick(1);
    check("show_seg1_wr", SEG_1, 32'hA5A5_0001);
    WR_IDX = 3'd5; WR_DATA = 32'hC0DE_0005;
    tick(1);
    WR_VALID = 1'b0;
    check("show_seg5_wr", SEG_5, 32'hC0DE_0005);

    bad = 0;
    for (int c = 0; c < 30; c++) begin
      tick(1);
      if (CUR_PAGE != 2'd2 || !SHOWING) bad++;
    end
    check("urgent_hold", bad, 0);

    // Sole page 3, then disable everything
    URGENT = 4'd0; PAGE_EN = 4'b1000;
    tick(1);
    check("p3_busy", BUSY, 1'b1);
    wait_show("p3_show");
    check("p3_page", CUR_PAGE, 2'd3);
    check("p3_seg0", SEG_0, 32'h3333_0000);
    PAGE_EN = 4'd0;
    tick(1);
    check("idle_showing", SHOWING, 1'b0);
    check("idle_busy", BUSY, 1'b0);
    for (int k = 0; k < 8; k++) check($sformatf("idle_seg%0d", k), seg_w[k], BLNK);

    // Reset mid-LOAD at idx 4
    PAGE_EN = 4'b0010;
    tick(1);
    tick(4);
    check("mid_seg0", SEG_0, 32'h1111_1111);
    check("mid_seg3", SEG_3, 32'h4444_4444);
    check("mid_busy", BUSY, 1'b1);
    RST = 1'b0;
    #1;
    check("arst_busy", BUSY, 1'b0);
    check("arst_showing", SHOWING, 1'b0);
    check("arst_page", CUR_PAGE, 2'd0);
    check("arst_seg0", SEG_0, BLNK);
    check("arst_seg3", SEG_3, BLNK);
    PAGE_EN = 4'b1001;
    tick(2);
    RST = 1'b1;
    tick(1);
    check("rel_busy", BUSY, 1'b1);
    check("rel_page", CUR_PAGE, 2'd3);
    wait_show("rel_show");
    check("rel_buf_cleared", SEG_0, 32'd0);

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/seg_page_scheduler.md
SEG_PAGE_SCHEDULER -- requirements
Module: seg_page_scheduler

Interface
REQ-001 SHALL have parameter DWELL_MAX, default 24'd9_999_999: SHOW-state cycles per page before rotation is considered.
REQ-002 SHALL have parameter BLANK, default 32'h0000_0000: pattern driven on all SEG_n when no page is enabled.
REQ-003 CLK  input  1  clock; all state changes on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 WR_VALID  input  1  write request.
REQ-006 WR_READY  output  1  write accepted when high together with WR_VALID.
REQ-007 WR_PAGE  input  2  target page 0..3.
REQ-008 WR_IDX  input  3  target word 0..7 within the page.
REQ-009 WR_DATA  input  32  four 8-bit segment patterns, MSB byte first.
REQ-010 PAGE_EN  input  4  per-page display enable.
REQ-011 URGENT  input  4  per-page priority request.
REQ-012 SEG_0..SEG_7  output  32 each  words feeding the 8-word dynamic display driver.
REQ-013 CUR_PAGE  output  2  page currently loaded or shown.
REQ-014 BUSY  output  1  high in LOAD.
REQ-015 SHOWING  output  1  high in SHOW.

Function
REQ-016 SHALL hold a 4-page x 8-word x 32-bit buffer; an accepted write stores WR_DATA at buf[WR_PAGE][WR_IDX] at that edge.
REQ-017 WR_READY SHALL be 0 only in LOAD while WR_PAGE equals CUR_PAGE; otherwise 1 (combinational).
REQ-018 FSM states SHALL be IDLE, LOAD, SHOW.
REQ-019 IDLE: SEG_0..7 = BLANK; when any PAGE_EN bit is set, select a page (REQ-024) and enter LOAD with index 0.
REQ-020 LOAD: each cycle copies buf[CUR_PAGE][idx] to SEG_idx, idx increments; after idx 7 enter SHOW with dwell counter 0; LOAD lasts exactly 8 cycles and is never aborted except by reset.
REQ-021 SHOW: dwell counter increments each cycle; an accepted write to CUR_PAGE also updates SEG_WR_IDX at the same edge.
REQ-022 SHOW, counter == DWELL_MAX: counter clears; if a different eligible page exists, select it and enter LOAD; else stay in SHOW.
REQ-023 SHOW, PAGE_EN[CUR_PAGE] cleared: next cycle select another eligible page and enter LOAD, or enter IDLE (outputs BLANK at that edge) if none enabled.
REQ-024 Eligible set = enabled urgent pages if any, else enabled pages; selection is round-robin starting at CUR_PAGE+1 modulo 4.
REQ-025 Preemption: in SHOW, if URGENT[CUR_PAGE] is 0 and any enabled page is urgent, enter LOAD of the lowest-index enabled urgent page at the next edge regardless of counter.
REQ-026 Changes to PAGE_EN/URGENT during LOAD SHALL be evaluated only after entering SHOW.
REQ-027 Dwell counter SHALL be 24 bits and wrap to 0 only via REQ-022.

Reset
REQ-028 With RST low: state IDLE, SEG_0..7 = BLANK, CUR_PAGE = 0, BUSY = 0, SHOWING = 0, idx = 0, counter = 0, all buffer words = 0.
REQ-029 RST assertion mid-LOAD or mid-SHOW SHALL take effect immediately; after release, operation restarts from IDLE.

Verification
REQ-030 Write page 1 words 0..7 = 32'h11111111*(k+1), PAGE_EN=4'b0010 -> BUSY 8 cycles, then SHOWING=1, SEG_k = written values, CUR_PAGE=1.
REQ-031 DWELL_MAX=4, PAGE_EN=4'b1011, start on page 0 -> page sequence 0,1,3,0 with each SHOW lasting 5 cycles between 8-cycle LOADs.
REQ-032 Showing page 0, URGENT=4'b0100, PAGE_EN=4'b0101 -> LOAD of page 2 starts next edge; while page 2 urgent, rotation never returns to page 0.
REQ-033 During LOAD of page 2, write to page 2 -> WR_READY=0 until SHOW; simultaneous write to page 3 accepted; write to page 2 idx 5 in SHOW -> SEG_5 updates same edge.
REQ-034 Showing sole page 3, PAGE_EN cleared -> IDLE next edge, SEG_0..7 = BLANK, SHOWING=0.
REQ-035 RST low during LOAD at idx 4 -> all outputs at reset values immediately; after release with PAGE_EN set, LOAD restarts at idx 0 of page chosen from CUR_PAGE=0.
